ycr1_pipe_mprf_mp: RTL and testbench

Parametrised multi-port register file for the ycr1 pipeline. Supports configurable data width, depth (RV32E 16 / RV32I 32), and read/write port counts.
Array has no per-entry reset. A hardware init sweep clears all entries after reset or on request, so the array can map to dense flops/latches.
Sits between EXU and writeback. x0 is hardwired to zero.

---
 rtl/ycr1_pipe_mprf_mp.sv | 133 +++++++++++++
 tb/tb_ycr1_pipe_mprf_mp.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/ycr1_pipe_mprf_mp.sv
// ycr1 multi-port register file: x0 hardwired to zero, array cleared by a hardware init sweep.
// Optional macro YCR1_MPRF_RD_STAGE_EN registers read data with write-first bypass.
module ycr1_pipe_mprf_mp #(
    parameter int XLEN   = 32,
    parameter int DEPTH  = 32,
    parameter int AWIDTH = $clog2(DEPTH),
    parameter int NUM_RD = 2,
    parameter int NUM_WR = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_RD*AWIDTH-1:0] rd_addr_i,
    output logic [NUM_RD*XLEN-1:0]   rd_data_o,
    input  logic [NUM_WR-1:0]        wr_req_i,
    input  logic [NUM_WR*AWIDTH-1:0] wr_addr_i,
    input  logic [NUM_WR*XLEN-1:0]   wr_data_i,
    input  logic                     init_req_i,
    output logic                     init_busy_o,
    output logic [XLEN-1:0]          func_return_val_o
);

    typedef enum logic {ST_CLEAR, ST_IDLE} state_t;

    localparam logic [AWIDTH-1:0] LAST = AWIDTH'(DEPTH - 1);

    state_t            r_state;
    logic [AWIDTH-1:0] r_ptr;
    logic              r_busy;
    logic [XLEN-1:0]   r_mem [DEPTH];

    logic [AWIDTH-1:0] w_wr_addr [NUM_WR];
    logic [XLEN-1:0]   w_wr_data [NUM_WR];
    logic [NUM_WR-1:0] w_wr_en;
    logic [AWIDTH-1:0] w_rd_addr [NUM_RD];
    logic [XLEN-1:0]   w_rd_arr  [NUM_RD];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_CLEAR;
            r_ptr   <= AWIDTH'(1);
            r_busy  <= 1'b1;
        end else begin
            case (r_state)
                ST_CLEAR: begin
                    r_ptr <= r_ptr + AWIDTH'(1);
                    if (r_ptr == LAST) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    if (init_req_i) begin
                        r_state <= ST_CLEAR;
                        r_ptr   <= AWIDTH'(1);
                        r_busy  <= 1'b1;
                    end
                end
            endcase
        end
    end

    assign init_busy_o = r_busy;

    always_comb begin
        for (int unsigned j = 0; j < NUM_WR; j++) begin
            w_wr_addr[j] = wr_addr_i[j*AWIDTH +: AWIDTH];
            w_wr_data[j] = wr_data_i[j*XLEN +: XLEN];
            w_wr_en[j]   = wr_req_i[j] && (w_wr_addr[j] != '0) && (w_wr_addr[j] <= LAST) && !r_busy;
        end
    end

    // No reset on the array; ascending port order lets the youngest write win a collision.
    always_ff @(posedge clk) begin
        if (r_busy) begin
            r_mem[r_ptr] <= '0;
        end else begin
            for (int unsigned j = 0; j < NUM_WR; j++) begin
                if (w_wr_en[j]) r_mem[w_wr_addr[j]] <= w_wr_data[j];
            end
        end
    end

    always_comb begin
        for (int unsigned k = 0; k < NUM_RD; k++) begin
            w_rd_addr[k] = rd_addr_i[k*AWIDTH +: AWIDTH];
            w_rd_arr[k]  = '0;
            if (!r_busy && (w_rd_addr[k] != '0) && (w_rd_addr[k] <= LAST))
                w_rd_arr[k] = r_mem[w_rd_addr[k]];
        end
    end

`ifdef YCR1_MPRF_RD_STAGE_EN
    logic [XLEN-1:0] r_rd_data [NUM_RD];
    logic [XLEN-1:0] w_rd_next [NUM_RD];

    // Enabled writes already exclude x0, out-of-range and busy, so the bypass needs no extra gating.
    always_comb begin
        for (int unsigned k = 0; k < NUM_RD; k++) begin
            w_rd_next[k] = w_rd_arr[k];
            for (int unsigned j = 0; j < NUM_WR; j++) begin
                if (w_wr_en[j] && (w_wr_addr[j] == w_rd_addr[k])) w_rd_next[k] = w_wr_data[j];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned k = 0; k < NUM_RD; k++) r_rd_data[k] <= '0;
        end else begin
            for (int unsigned k = 0; k < NUM_RD; k++) r_rd_data[k] <= w_rd_next[k];
        end
    end

    always_comb begin
        rd_data_o = '0;
        for (int unsigned k = 0; k < NUM_RD; k++) rd_data_o[k*XLEN +: XLEN] = r_rd_data[k];
    end
`else
    always_comb begin
        rd_data_o = '0;
        for (int unsigned k = 0; k < NUM_RD; k++) rd_data_o[k*XLEN +: XLEN] = w_rd_arr[k];
    end
`endif

    generate
        if (DEPTH > 10) begin : g_a0
            assign func_return_val_o = r_busy ? '0 : r_mem[10];
        end else begin : g_no_a0
            assign func_return_val_o = '0;
        end
    endgenerate

endmodule

// File: tb/tb_ycr1_pipe_mprf_mp.sv
// Self-checking bench for ycr1_pipe_mprf_mp (DEPTH=32, 2 read / 2 write ports).
module tb_ycr1_pipe_mprf_mp;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [9:0]  rd_addr;
    logic [63:0] rd_data;
    logic [1:0]  wr_req;
    logic [9:0]  wr_addr;
    logic [63:0] wr_data;
    logic        init_req;
    logic        busy;
    logic [31:0] fret;

    int n_checks = 0;
    int n_pass   = 0;

    ycr1_pipe_mprf_mp #(.XLEN(32), .DEPTH(32), .NUM_RD(2), .NUM_WR(2)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .rd_addr_i         (rd_addr),
        .rd_data_o         (rd_data),
        .wr_req_i          (wr_req),
        .wr_addr_i         (wr_addr),
        .wr_data_i         (wr_data),
        .init_req_i        (init_req),
        .init_busy_o       (busy),
        .func_return_val_o (fret)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic we0; logic [4:0] a0; logic [31:0] d0;
        logic we1; logic [4:0] a1; logic [31:0] d1;
        logic [4:0] ra0; logic [4:0] ra1;
        logic [31:0] e0; logic [31:0] e1; logic [31:0] efr;
    } vec_t;

    vec_t        vecs [7];
    logic [31:0] model [32];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    // Presents read addresses and waits until the data for them is valid.
    task automatic do_read(input logic [4:0] r0, input logic [4:0] r1);
        rd_addr = {r1, r0};
`ifdef YCR1_MPRF_RD_STAGE_EN
        tick();
`else
        #1;
`endif
    endtask

    task automatic clear_wr();
        wr_req = '0; wr_addr = '0; wr_data = '0;
    endtask

    // Counts edges (from the current one) until busy is seen low; includes edges already counted.
    task automatic count_busy(input int start, output int cnt);
        cnt = start;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (!busy) break;
            cnt++;
        end
    endtask

    initial begin
        int cnt;
        rst_n = 1'b0; init_req = 1'b0; rd_addr = '0;
        clear_wr();
        repeat (3) @(posedge clk);
        #1;
        chk("reset_busy", {31'd0, busy}, 32'd1);
        chk("reset_rd", rd_data[31:0] | rd_data[63:32], 32'd0);
        chk("reset_fret", fret, 32'd0);

        // Release reset: busy observed high after 30 edges, falls at edge 31.
        rst_n = 1'b1;
        count_busy(1, cnt);
        chk("init_sweep_len", 32'(cnt), 32'd31);

        for (int i = 0; i < 32; i++) begin
            do_read(5'(i), 5'(31 - i));
            chk("post_sweep_zero", rd_data[31:0] | rd_data[63:32], 32'd0);
        end

        vecs[0] = '{1'b1, 5'd5,  32'hDEADBEEF, 1'b0, 5'd0, 32'h0,        5'd5,  5'd5, 32'hDEADBEEF, 32'hDEADBEEF, 32'h0};
        vecs[1] = '{1'b1, 5'd0,  32'h00001234, 1'b0, 5'd0, 32'h0,        5'd0,  5'd5, 32'h0,        32'hDEADBEEF, 32'h0};
        vecs[2] = '{1'b1, 5'd7,  32'h11111111, 1'b1, 5'd7, 32'h22222222, 5'd7,  5'd7, 32'h22222222, 32'h22222222, 32'h0};
        vecs[3] = '{1'b0, 5'd6,  32'h0BADBAD0, 1'b1, 5'd6, 32'hCAFEF00D, 5'd6,  5'd7, 32'hCAFEF00D, 32'h22222222, 32'h0};
        vecs[4] = '{1'b1, 5'd31, 32'hFFFFFFFF, 1'b1, 5'd1, 32'h00000001, 5'd31, 5'd1, 32'hFFFFFFFF, 32'h00000001, 32'h0};
        vecs[5] = '{1'b1, 5'd10, 32'h00000042, 1'b0, 5'd0, 32'h0,        5'd10, 5'd0, 32'h00000042, 32'h0,        32'h42};
        vecs[6] = '{1'b0, 5'd5,  32'h0,        1'b0, 5'd5, 32'h0,        5'd5,  5'd6, 32'hDEADBEEF, 32'hCAFEF00D, 32'h42};

        for (int v = 0; v < 7; v++) begin
            wr_req  = {vecs[v].we1, vecs[v].we0};
            wr_addr = {vecs[v].a1, vecs[v].a0};
            wr_data = {vecs[v].d1, vecs[v].d0};
            tick();
            clear_wr();
            do_read(vecs[v].ra0, vecs[v].ra1);
            chk($sformatf("vec%0d_rd0", v), rd_data[31:0], vecs[v].e0);
            chk($sformatf("vec%0d_rd1", v), rd_data[63:32], vecs[v].e1);
            chk($sformatf("vec%0d_fret", v), fret, vecs[v].efr);
        end

        // Write to x3 with port1 reading x3 in the same cycle.
        rd_addr = {5'd3, 5'd0};
        wr_req = 2'b01; wr_addr = {5'd0, 5'd3}; wr_data = {32'h0, 32'hA5A5A5A5};
`ifndef YCR1_MPRF_RD_STAGE_EN
        #1;
        chk("no_bypass_old", rd_data[63:32], 32'h0);
`endif
        tick();
        clear_wr();
        chk("write_first_x3", rd_data[63:32], 32'hA5A5A5A5);

        // Init request while x10 holds 0x42.
        rd_addr = {5'd3, 5'd10};
        init_req = 1'b1;
        tick();
        init_req = 1'b0;
        chk("init_busy_rise", {31'd0, busy}, 32'd1);
        chk("init_fret_zero", fret, 32'd0);
        cnt = 1;
        for (int i = 0; i < 100; i++) begin
            if (i == 0) begin
                wr_req = 2'b01; wr_addr = {5'd0, 5'd10}; wr_data = {32'h0, 32'h99};
            end else if (i == 4) begin
                init_req = 1'b1;
            end
            tick();
            clear_wr();
            init_req = 1'b0;
            if (i == 0) chk("busy_rd_zero", rd_data[31:0] | rd_data[63:32], 32'd0);
            if (!busy) break;
            cnt++;
        end
        chk("reinit_len", 32'(cnt), 32'd31);
        do_read(5'd10, 5'd5);
        chk("x10_cleared", rd_data[31:0], 32'd0);
        chk("x5_cleared", rd_data[63:32], 32'd0);
        chk("fret_cleared", fret, 32'd0);

        // Reset asserted 12 edges into a sweep.
        init_req = 1'b1;
        tick();
        init_req = 1'b0;
        repeat (11) tick();
        chk("midsweep_busy", {31'd0, busy}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("rst_busy_a", {31'd0, busy}, 32'd1);
        tick();
        chk("rst_busy_b", {31'd0, busy}, 32'd1);
        rst_n = 1'b1;
        count_busy(1, cnt);
        chk("restart_len", 32'(cnt), 32'd31);

        // Randomized traffic against an array model of the architectural registers.
        for (int i = 0; i < 32; i++) model[i] = '0;
        for (int it = 0; it < 300; it++) begin
            logic [4:0]  wa [2];
            logic [31:0] wd [2];
            logic [1:0]  wq;
            logic [4:0]  ra [2];
            for (int p = 0; p < 2; p++) begin
                wa[p] = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 3)) : 5'($urandom_range(0, 31));
                wd[p] = $urandom;
                ra[p] = ($urandom_range(0, 3) == 0) ? wa[p] : 5'($urandom_range(0, 31));
            end
            wq = 2'($urandom_range(0, 3));
            wr_req = wq; wr_addr = {wa[1], wa[0]}; wr_data = {wd[1], wd[0]};
            rd_addr = {ra[1], ra[0]};
`ifndef YCR1_MPRF_RD_STAGE_EN
            #1;
            chk("rnd_rd0_pre", rd_data[31:0], model[ra[0]]);
            chk("rnd_rd1_pre", rd_data[63:32], model[ra[1]]);
`endif
            tick();
            for (int p = 0; p < 2; p++)
                if (wq[p] && wa[p] != 5'd0) model[wa[p]] = wd[p];
`ifdef YCR1_MPRF_RD_STAGE_EN
            chk("rnd_rd0", rd_data[31:0], model[ra[0]]);
            chk("rnd_rd1", rd_data[63:32], model[ra[1]]);
`endif
            chk("rnd_fret", fret, model[10]);
        end
        clear_wr();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
